// File: rtl/score_event_serializer.sv
// Turns monster/boss/asteroid kill pulses into a stream of stage-scaled score additions.
// Each source keeps a saturating backlog, and sources are served round-robin through a valid/ready offer.
module score_event_serializer #(
  parameter int PENDING_WIDTH   = 4,
  parameter int MONSTER_POINTS  = 1,
  parameter int BOSS_POINTS     = 5,
  parameter int ASTEROID_POINTS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     monster_died_pulse,
  input  logic                     boss_died_pulse,
  input  logic                     asteroid_exploded_pulse,
  input  logic [2:0]               stage_num,
  input  logic                     game_over,
  input  logic                     add_ready,
  output logic                     add_valid,
  output logic [5:0]               add_amount,
  output logic [PENDING_WIDTH+1:0] pending_total,
  output logic                     overflow
);

  localparam int TOTAL_WIDTH = PENDING_WIDTH + 2;
  localparam logic [PENDING_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                   state, next_state;
  logic [PENDING_WIDTH-1:0] cnt [3];
  logic [1:0]               rr_ptr;
  logic [5:0]               amount_q;

  logic [2:0] pulse, inc_vec, dec_vec, pending;
  logic       can_select, grant_valid, grant_sel;
  logic [1:0] grant_idx, cand;
  logic [2:0] cand_sum, eff_stage;
  logic [5:0] src_points, sel_amount;

  assign pulse   = {asteroid_exploded_pulse, boss_died_pulse, monster_died_pulse};
  assign inc_vec = pulse & {3{~game_over}};

  // A pulse arriving this cycle already counts as pending, so an idle serializer can offer it on the very next cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pending[i] = (cnt[i] != '0) || pulse[i];
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    cand_sum    = '0;
    cand        = '0;
    for (int k = 0; k < 3; k++) begin
      cand_sum = {1'b0, rr_ptr} + 3'(k);
      cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
      if (!grant_valid && pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign can_select = !game_over && ((state == IDLE) || add_ready);
  assign grant_sel  = can_select && grant_valid;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dec_vec[i] = grant_sel && (grant_idx == 2'(i));
    end
  end

  // Stage 0 still scores at x1.
  always_comb begin
    eff_stage = (stage_num == 3'd0) ? 3'd1 : stage_num;
    case (grant_idx)
      2'd1:    src_points = 6'(BOSS_POINTS);
      2'd2:    src_points = 6'(ASTEROID_POINTS);
      default: src_points = 6'(MONSTER_POINTS);
    endcase
    sel_amount = src_points * {3'b000, eff_stage};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (grant_sel) next_state = OFFER;
      OFFER: if (add_ready) next_state = grant_sel ? OFFER : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      overflow <= 1'b0;
      rr_ptr   <= 2'd0;
      amount_q <= 6'd0;
    end else begin
      if (grant_sel) begin
        rr_ptr   <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
        amount_q <= sel_amount;
      end
      for (int i = 0; i < 3; i++) begin
        if (game_over) begin
          cnt[i] <= '0;
        end else if (inc_vec[i] && !dec_vec[i]) begin
          if (cnt[i] == CNT_MAX) overflow <= 1'b1;
          else                   cnt[i]   <= cnt[i] + 1'b1;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    add_valid     = (state == OFFER);
    add_amount    = (state == OFFER) ? amount_q : 6'd0;
    pending_total = TOTAL_WIDTH'(cnt[0]) + TOTAL_WIDTH'(cnt[1]) + TOTAL_WIDTH'(cnt[2]);
  end

endmodule

// File: tb/tb_score_event_serializer.sv
// Directed bench for score_event_serializer; the expected values are worked out by hand from the scoring rules.
module tb_score_event_serializer;

  logic       clk = 1'b0;
  logic       reset, monster_died_pulse, boss_died_pulse, asteroid_exploded_pulse;
  logic [2:0] stage_num;
  logic       game_over, add_ready;
  logic       add_valid;
  logic [5:0] add_amount;
  logic [5:0] pending_total;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int offers;

  score_event_serializer dut (
    .clk                     (clk),
    .reset                   (reset),
    .monster_died_pulse      (monster_died_pulse),
    .boss_died_pulse         (boss_died_pulse),
    .asteroid_exploded_pulse (asteroid_exploded_pulse),
    .stage_num               (stage_num),
    .game_over               (game_over),
    .add_ready               (add_ready),
    .add_valid               (add_valid),
    .add_amount              (add_amount),
    .pending_total           (pending_total),
    .overflow                (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic b, input logic a);
    monster_died_pulse      = m;
    boss_died_pulse         = b;
    asteroid_exploded_pulse = a;
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; game_over = 1'b0; add_ready = 1'b1; stage_num = 3'd1;
    applyStimulus(0, 0, 0);
    #1;
    doReset();
    checkOutput("rst_valid",   add_valid,     0);
    checkOutput("rst_amount",  add_amount,    0);
    checkOutput("rst_pending", pending_total, 0);
    checkOutput("rst_ovf",     overflow,      0);

    // single monster, stage 3
    stage_num = 3'd3; add_ready = 1'b1;
    applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    checkOutput("mon_valid",   add_valid,     1);
    checkOutput("mon_amount",  add_amount,    3);
    checkOutput("mon_pending", pending_total, 0);
    tick();
    checkOutput("mon_valid_drop", add_valid,  0);
    checkOutput("mon_pending2", pending_total, 0);

    // round robin resumes after the monster grant: boss before monster
    applyStimulus(1, 1, 0); tick(); applyStimulus(0, 0, 0);
    checkOutput("rr_first",   add_amount,    15);
    checkOutput("rr_pend1",   pending_total, 1);
    tick();
    checkOutput("rr_second",  add_amount,    3);
    checkOutput("rr_valid2",  add_valid,     1);
    tick();
    checkOutput("rr_done",    add_valid,     0);

    // all three at once, stage 2
    doReset();
    stage_num = 3'd2;
    applyStimulus(1, 1, 1); tick(); applyStimulus(0, 0, 0);
    checkOutput("all_amt0",  add_amount,    2);
    checkOutput("all_pend0", pending_total, 2);
    tick();
    checkOutput("all_amt1",  add_amount,    10);
    checkOutput("all_pend1", pending_total, 1);
    tick();
    checkOutput("all_amt2",  add_amount,    4);
    checkOutput("all_val2",  add_valid,     1);
    tick();
    checkOutput("all_done",  add_valid,     0);

    // boss held under backpressure, stage 7
    doReset();
    stage_num = 3'd7; add_ready = 1'b0;
    applyStimulus(0, 1, 0); tick(); applyStimulus(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold_valid%0d", i), add_valid,  1);
      checkOutput($sformatf("hold_amt%0d", i),   add_amount, 35);
      stage_num = 3'(i);
      tick();
    end
    checkOutput("hold_c6_amt", add_amount, 35);
    add_ready = 1'b1;
    tick();
    checkOutput("hold_release", add_valid, 0);

    // 17 asteroid pulses with no acceptance
    doReset();
    checkOutput("rst_again_valid", add_valid, 0);
    stage_num = 3'd1; add_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 0, 1); tick();
      if (i == 15) begin
        checkOutput("sat_pend16", pending_total, 15);
        checkOutput("sat_ovf16",  overflow,      0);
      end
    end
    applyStimulus(0, 0, 0);
    checkOutput("sat_pend", pending_total, 15);
    checkOutput("sat_ovf",  overflow,      1);
    checkOutput("sat_amt",  add_amount,    2);
    add_ready = 1'b1;
    offers = 0;
    for (int k = 0; k < 40; k++) begin
      if (add_valid) offers++;
      tick();
    end
    checkOutput("sat_offers", offers,        16);
    checkOutput("sat_drain",  pending_total, 0);
    checkOutput("sat_sticky", overflow,      1);
    doReset();
    checkOutput("ovf_cleared", overflow, 0);

    // stage 0 scores x1
    stage_num = 3'd0; add_ready = 1'b1;
    applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    checkOutput("stage0_amt", add_amount, 1);

    // reset in the middle of an offer with 4 pending; coincident pulse ignored
    doReset();
    stage_num = 3'd1; add_ready = 1'b0;
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(0, 0, 0);
    checkOutput("mid_pend",  pending_total, 4);
    checkOutput("mid_valid", add_valid,     1);
    reset = 1'b1; applyStimulus(1, 0, 0);
    tick();
    reset = 1'b0; applyStimulus(0, 0, 0);
    checkOutput("mid_rst_valid", add_valid,     0);
    checkOutput("mid_rst_pend",  pending_total, 0);
    checkOutput("mid_rst_ovf",   overflow,      0);
    checkOutput("mid_rst_amt",   add_amount,    0);
    tick();
    checkOutput("mid_rst_ignore", add_valid, 0);

    // game_over flushes counters but lets the held offer finish
    doReset();
    stage_num = 3'd1; add_ready = 1'b0;
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(0, 0, 0);
    checkOutput("go_pend_pre", pending_total, 2);
    game_over = 1'b1; applyStimulus(0, 1, 0);
    tick();
    checkOutput("go_pend",  pending_total, 0);
    checkOutput("go_valid", add_valid,     1);
    checkOutput("go_amt",   add_amount,    1);
    add_ready = 1'b1;
    tick();
    checkOutput("go_idle", add_valid, 0);
    tick();
    checkOutput("go_ignore_valid", add_valid,     0);
    checkOutput("go_ignore_pend",  pending_total, 0);
    game_over = 1'b0; applyStimulus(0, 0, 0);
    tick();
    checkOutput("go_after", add_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_event_serializer.md
SCORE_EVENT_SERIALIZER -- requirements
Module: score_event_serializer

Interface
REQ-001 SHALL have parameter PENDING_WIDTH, default 4, meaning bit width of each per-source pending-event counter (max 15).
REQ-002 SHALL have parameter MONSTER_POINTS, default 1, meaning base points per monster kill.
REQ-003 SHALL have parameter BOSS_POINTS, default 5, meaning base points per boss kill.
REQ-004 SHALL have parameter ASTEROID_POINTS, default 2, meaning base points per asteroid explosion.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports monster_died_pulse, boss_died_pulse and asteroid_exploded_pulse, each input, 1, one-cycle event pulses.
REQ-009 SHALL have port stage_num, input, 3, current game stage and score multiplier.
REQ-010 SHALL have port game_over, input, 1, level-sensitive flush/hold request.
REQ-011 SHALL have port add_ready, input, 1, score counter able to accept an addition this cycle.
REQ-012 SHALL have port add_valid, output, 1, an addition is offered.
REQ-013 SHALL have port add_amount, output, 6, points to add; valid only while add_valid=1.
REQ-014 SHALL have port pending_total, output, PENDING_WIDTH+2, sum of all pending counters.
REQ-015 SHALL have port overflow, output, 1, sticky flag set when an event was dropped.

Function
REQ-016 SHALL keep one pending counter per source; an input pulse increments its counter on the next edge.
REQ-017 SHALL saturate each counter at 2^PENDING_WIDTH-1; a pulse arriving at saturation is dropped and overflow is set.
REQ-018 SHALL apply increment and decrement to the same counter in the same cycle as a net change of zero, with no overflow.
REQ-019 SHALL accept any combination of the three pulses in one cycle, each counted independently.
REQ-020 SHALL implement FSM states IDLE and OFFER, both registered.
REQ-021 SHALL go IDLE->OFFER when any counter is nonzero and game_over=0, select a source round-robin (monster, boss, asteroid; start after the last granted source), decrement that counter, and register add_amount.
REQ-022 SHALL compute add_amount = source points x effective stage, where effective stage = stage_num, or 1 when stage_num=0; add_amount SHALL be sampled at selection time and not change while offered.
REQ-023 SHALL hold add_valid=1 and add_amount stable in OFFER until add_ready=1 is sampled.
REQ-024 SHALL, on the handshake cycle, return to IDLE if no counter is pending, or otherwise select the next source immediately, giving back-to-back offers one per cycle while add_ready=1.
REQ-025 SHALL have minimum latency of 1 cycle from a pulse on cycle N with empty counters to add_valid=1 on cycle N+1.
REQ-026 SHALL, while game_over=1, clear all counters, make no new selection, and still complete an offer already in OFFER before entering IDLE; pulses during game_over SHALL be ignored.
REQ-027 SHALL drive pending_total combinationally from the counter registers.

Reset
REQ-028 SHALL, with reset=1 at an edge, clear all counters, overflow and the round-robin pointer, enter IDLE, and drive add_valid=0, add_amount=0 and pending_total=0, including when reset occurs mid-offer.
REQ-029 SHALL ignore event pulses coincident with reset.

Verification
REQ-030 SHALL cover: single monster pulse, stage_num=3, add_ready=1 -> add_valid high on the next cycle only, add_amount=3, pending_total returns to 0.
REQ-031 SHALL cover: all three pulses in one cycle, stage_num=2, add_ready=1 -> three consecutive offers with amounts 2, 10, 4 in that order.
REQ-032 SHALL cover: boss pulse, stage_num=7, add_ready held 0 for 5 cycles -> add_valid=1 and add_amount=35 held stable for all 5 cycles; handshake on cycle 6.
REQ-033 SHALL cover: 17 asteroid pulses with add_ready=0 -> pending_total=15 (one pending plus the held offer as appropriate), overflow=1, remainder dropped.
REQ-034 SHALL cover: stage_num=0 with a monster pulse -> add_amount=1.
REQ-035 SHALL cover: reset asserted while in OFFER with 4 pending -> next cycle add_valid=0, pending_total=0, overflow=0.
